// File: rtl/apb_cmd_master.sv
// APB requester: buffers read/write commands in a small FIFO, runs each one
// as a single APB transfer (SETUP then ACCESS, honouring PREADY wait states,
// aborting on timeout) and returns the result on a one-entry response port.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester interface
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = 8;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Read data returned to the requester: only reads carry PRDATA back.
  function automatic logic [DATA_WIDTH-1:0] rsp_data_sel(
    input logic                  is_write,
    input logic                  is_abort,
    input logic [DATA_WIDTH-1:0] rdata
  );
    if (is_write || is_abort) return '0;
    return rdata;
  endfunction

  cmd_t             fifo_mem [FIFO_DEPTH];
  cmd_t             push_entry;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             run;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic             capture;
  logic             abort;
  logic [TMO_W-1:0] tmo_cnt;
  state_t           state;
  state_t           state_next;

  // cmd_ready is derived from registered state only; run keeps it low while
  // reset is asserted so every output reads 0 during reset.
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = run && !full;
  assign push      = cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid || rsp_ready;
  assign head      = fifo_mem[rd_ptr];

  assign push_entry.write = cmd_write;
  assign push_entry.addr  = cmd_addr;
  assign push_entry.wdata = cmd_wdata;
  assign push_entry.strb  = cmd_write ? cmd_strb : '0;

  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);

  // Enable flag: goes high on the first edge after reset release.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Command storage: payload only, no reset needed.
  always_ff @(posedge PCLK) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer sequencer state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: every transfer returns through IDLE before the next SETUP.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && slot_free) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counts ACCESS cycles spent waiting for PREADY; restarts at each SETUP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // APB address/data registers: loaded on pop, held through SETUP and ACCESS.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (pop) begin
      PWRITE <= head.write;
      PADDR  <= head.addr;
      PWDATA <= head.wdata;
      PSTRB  <= head.strb;
    end
  end

  // Response slot: captured at transfer end, held until the handshake.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (capture || abort) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= rsp_data_sel(PWRITE, abort, PRDATA);
      rsp_err     <= abort || PSLVERR;
      rsp_timeout <= abort;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small behavioural APB memory slave.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_cmd_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- APB slave model ----------------
  int          slv_wait = 1;     // ACCESS cycle (1-based) in which PREADY rises
  logic        slv_hang = 1'b0;  // never raise PREADY
  logic        slv_err  = 1'b0;
  logic        mem_clr  = 1'b1;
  int          acc_cnt  = 0;
  logic [31:0] smem [1024];

  assign PREADY  = PSEL && PENABLE && !slv_hang && (acc_cnt == slv_wait - 1);
  assign PRDATA  = smem[PADDR];
  assign PSLVERR = slv_err;

  always @(posedge PCLK) begin
    acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) smem[i] <= '0;
    end else if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) smem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

  // ---------------- bus monitor ----------------
  int          psel_cnt = 0;
  int          pen_cnt  = 0;
  int          rv_cnt   = 0;
  int          stab_err = 0;
  logic [3:0]  last_strb = '0;
  logic [9:0]  s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_strb = '0;
  logic        s_write = 1'b0;

  always @(negedge PCLK) begin
    if (PSEL)      psel_cnt++;
    if (PENABLE)   pen_cnt++;
    if (rsp_valid) rv_cnt++;
    if (PSEL && !PENABLE) begin
      s_addr = PADDR; s_wdata = PWDATA; s_strb = PSTRB; s_write = PWRITE;
      last_strb = PSTRB;
    end else if (PSEL && PENABLE) begin
      if (PADDR !== s_addr || PWDATA !== s_wdata || PSTRB !== s_strb || PWRITE !== s_write)
        stab_err++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    while (!cmd_ready && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [31:0] er, input logic ee,
                         input logic et);
    int n = 0;
    @(negedge PCLK);
    while (!rsp_valid && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({name, "_rdata"}, 64'(rsp_rdata), 64'(er));
    chk({name, "_err"}, 64'(rsp_err), 64'(ee));
    chk({name, "_timeout"}, 64'(rsp_timeout), 64'(et));
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wt;
    logic        serr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0, e0, r0, n;

    vecs[0] = '{1'b1, 10'h020, 32'hDEADBEEF, 4'hF, 4, 1'b0, 32'h0,        1'b0, 4'hF};
    vecs[1] = '{1'b0, 10'h020, 32'h0,        4'hF, 2, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0};
    vecs[2] = '{1'b1, 10'h005, 32'h11223344, 4'hF, 1, 1'b1, 32'h0,        1'b1, 4'hF};
    vecs[3] = '{1'b1, 10'h021, 32'hAABBCCDD, 4'h5, 1, 1'b0, 32'h0,        1'b0, 4'h5};
    vecs[4] = '{1'b0, 10'h021, 32'h0,        4'hF, 1, 1'b0, 32'h00BB00DD, 1'b0, 4'h0};
    vecs[5] = '{1'b0, 10'h005, 32'h0,        4'h0, 3, 1'b0, 32'h0,        1'b0, 4'h0};
    vecs[6] = '{1'b0, 10'h020, 32'h0,        4'hF, 1, 1'b1, 32'hDEADBEEF, 1'b1, 4'h0};
    vecs[7] = '{1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 2, 1'b0, 32'h0,        1'b0, 4'hF};
    vecs[8] = '{1'b0, 10'h3FF, 32'h0,        4'hF, 1, 1'b0, 32'hFFFFFFFF, 1'b0, 4'h0};

    // reset state
    PRESET = 1'b1;
    #22;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    mem_clr = 1'b0;
    @(posedge PCLK);
    #1 chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // latency of a zero-wait transfer
    slv_wait = 1; slv_err = 1'b0;
    send_cmd(1'b1, 10'h010, 32'h12345678, 4'hF);
    chk("lat_psel_n", 64'(PSEL), 64'd0);
    @(posedge PCLK); #1;
    chk("lat_psel_n1", 64'(PSEL), 64'd1);
    chk("lat_pen_n1", 64'(PENABLE), 64'd0);
    @(posedge PCLK); #1;
    chk("lat_pen_n2", 64'(PENABLE), 64'd1);
    chk("lat_rv_n2", 64'(rsp_valid), 64'd0);
    @(posedge PCLK); #1;
    chk("lat_rv_n3", 64'(rsp_valid), 64'd1);
    chk("lat_psel_n3", 64'(PSEL), 64'd0);
    get_rsp("lat", 32'h0, 1'b0, 1'b0);

    // table-driven single transfers
    for (int i = 0; i < 9; i++) begin
      slv_wait = vecs[i].wt;
      slv_err  = vecs[i].serr;
      p0 = psel_cnt;
      e0 = stab_err;
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      get_rsp($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
      chk($sformatf("vec%0d_psel_cycles", i), 64'(psel_cnt - p0), 64'(vecs[i].wt + 1));
      chk($sformatf("vec%0d_stable", i), 64'(stab_err - e0), 64'd0);
      chk($sformatf("vec%0d_pstrb", i), 64'(last_strb), 64'(vecs[i].exp_pstrb));
    end
    slv_err = 1'b0;
    slv_wait = 1;

    // timeout abort, then normal recovery
    slv_hang = 1'b1;
    p0 = psel_cnt; q0 = pen_cnt;
    send_cmd(1'b0, 10'h020, 32'h0, 4'h0);
    get_rsp("tmo", 32'h0, 1'b1, 1'b1);
    chk("tmo_psel_cycles", 64'(psel_cnt - p0), 64'd17);
    chk("tmo_access_cycles", 64'(pen_cnt - q0), 64'd16);
    slv_hang = 1'b0;
    send_cmd(1'b0, 10'h020, 32'h0, 4'h0);
    get_rsp("tmo_next", 32'hDEADBEEF, 1'b0, 1'b0);

    // back-pressure: full FIFO plus one in flight, responses in order
    rsp_ready = 1'b0;
    p0 = psel_cnt;
    send_cmd(1'b1, 10'h100, 32'h000000A1, 4'hF);
    send_cmd(1'b0, 10'h100, 32'h0, 4'hF);
    send_cmd(1'b1, 10'h101, 32'h000000B2, 4'hF);
    send_cmd(1'b0, 10'h101, 32'h0, 4'hF);
    send_cmd(1'b0, 10'h020, 32'h0, 4'hF);
    chk("bp_full_ready", 64'(cmd_ready), 64'd0);
    repeat (10) @(negedge PCLK);
    chk("bp_hold_ready", 64'(cmd_ready), 64'd0);
    chk("bp_hold_rv", 64'(rsp_valid), 64'd1);
    chk("bp_one_transfer", 64'(psel_cnt - p0), 64'd2);
    get_rsp("bp0", 32'h0, 1'b0, 1'b0);
    get_rsp("bp1", 32'h000000A1, 1'b0, 1'b0);
    get_rsp("bp2", 32'h0, 1'b0, 1'b0);
    get_rsp("bp3", 32'h000000B2, 1'b0, 1'b0);
    get_rsp("bp4", 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge PCLK);
    chk("bp_drained_ready", 64'(cmd_ready), 64'd1);

    // reset in the middle of ACCESS with commands queued
    slv_hang = 1'b1;
    send_cmd(1'b1, 10'h030, 32'h11111111, 4'hF);
    send_cmd(1'b1, 10'h031, 32'h22222222, 4'hF);
    send_cmd(1'b1, 10'h032, 32'h33333333, 4'hF);
    n = 0;
    while (!PENABLE && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("mr_in_access", 64'(PENABLE), 64'd1);
    repeat (2) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("mr_psel", 64'(PSEL), 64'd0);
    chk("mr_penable", 64'(PENABLE), 64'd0);
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mr_paddr", 64'(PADDR), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    slv_hang = 1'b0;
    p0 = psel_cnt; r0 = rv_cnt;
    @(posedge PCLK);
    #1 chk("mr_rel_ready", 64'(cmd_ready), 64'd1);
    repeat (20) @(negedge PCLK);
    chk("mr_no_transfer", 64'(psel_cnt - p0), 64'd0);
    chk("mr_no_response", 64'(rv_cnt - r0), 64'd0);
    send_cmd(1'b1, 10'h030, 32'h00005A5A, 4'hF);
    get_rsp("mr_wr", 32'h0, 1'b0, 1'b0);
    send_cmd(1'b0, 10'h030, 32'h0, 4'h0);
    get_rsp("mr_rd", 32'h00005A5A, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
